// File: rtl/ones_pkg.sv
// Shared definitions for the ones-counter family: serializer FSM states and
// the index-width helper used to size index/count ports.
package ones_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } ones_state_e;

    // Bits needed to address n positions; never returns 0 so ports stay legal.
    function automatic int unsigned ones_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ones_prio_enc.sv
// First-set-bit encoder over a mask. Returns the selected index and a flag
// that is set when more than one bit of the mask is set.
// Direction: LSB-first by default, MSB-first when ONES_IDX_MSB_FIRST_EN is defined.
module ones_prio_enc
    import ones_pkg::*;
#(
    parameter int unsigned Width = 16,
    parameter int unsigned IdxW  = ones_width(Width)
) (
    input  logic [Width-1:0] mask_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             multi_o
);

    // Priority scan; the last match written wins, so scan order picks the direction.
    always_comb begin
        idx_o = '0;
`ifdef ONES_IDX_MSB_FIRST_EN
        for (int i = 0; i < int'(Width); i++) begin
            if (mask_i[i]) idx_o = IdxW'(i);
        end
`else
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = IdxW'(i);
        end
`endif
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi_o = |(mask_i & (mask_i - Width'(1)));
    end

endmodule

// File: rtl/ones_index_serializer.sv
// Enumerates the set bits of an accepted vector, one index per output beat,
// with a running 1-based ordinal. An empty vector yields a single beat with
// out_none set. Emission order is selected by ONES_IDX_MSB_FIRST_EN.
module ones_index_serializer
    import ones_pkg::*;
#(
    parameter  int unsigned inCount  = 16,
    localparam int unsigned outCount = ones_width(inCount)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [inCount-1:0]  in_vec,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [outCount-1:0] out_idx,
    output logic [outCount:0]   out_count,
    output logic                out_last,
    output logic                out_none,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int unsigned CntW = outCount + 1;

    ones_state_e         state_q;
    logic [inCount-1:0]  mask_q;
    logic [CntW-1:0]     ord_q;
    logic                none_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [outCount-1:0] enc_idx;
    logic                enc_multi;
    logic [inCount-1:0]  clr_bit;

    ones_prio_enc #(
        .Width (inCount),
        .IdxW  (outCount)
    ) u_prio_enc (
        .mask_i  (mask_q),
        .idx_o   (enc_idx),
        .multi_o (enc_multi)
    );

    // One-hot of the bit being emitted; mask is zero in IDLE so the index reads 0 there.
    always_comb begin
        clr_bit = {{(inCount - 1){1'b0}}, 1'b1} << enc_idx;
    end

    // FSM, mask and ordinal; handshake flags are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            ord_q       <= '0;
            none_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q     <= StEmit;
                        mask_q      <= in_vec;
                        ord_q       <= (in_vec == '0) ? '0 : CntW'(1);
                        none_q      <= (in_vec == '0);
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        mask_q <= mask_q & ~clr_bit;
                        if (!enc_multi) begin
                            state_q     <= StIdle;
                            ord_q       <= '0;
                            none_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            ord_q <= ord_q + CntW'(1);
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs derive only from registers; last is gated so it stays low in IDLE.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        out_idx   = enc_idx;
        out_count = ord_q;
        out_last  = out_valid_q & ~enc_multi;
        out_none  = none_q;
    end

endmodule

// File: tb/tb_ones_index_serializer.sv
// Self-checking bench for ones_index_serializer. The expected beat list is
// built from the set bits of each vector; build with ONES_IDX_MSB_FIRST_EN
// defined to check the MSB-first ordering.
module tb_ones_index_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_vec;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_idx;
    logic [4:0]  out_count;
    logic        out_last;
    logic        out_none;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc;
    int seen_first;
    bit tail_ready;

    int got_idx[$], got_cnt[$], got_last[$], got_none[$], got_cyc[$];
    int exp_idx[$], exp_cnt[$], exp_last[$], exp_none[$];

    ones_index_serializer #(.inCount(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_count (out_count),
        .out_last  (out_last),
        .out_none  (out_none),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: list the set bits in emission order, ordinal 1..N, empty -> one none beat.
    task automatic model(input logic [15:0] v);
        exp_idx.delete(); exp_cnt.delete(); exp_last.delete(); exp_none.delete();
`ifdef ONES_IDX_MSB_FIRST_EN
        for (int i = 15; i >= 0; i--) if (v[i]) exp_idx.push_back(i);
`else
        for (int i = 0; i < 16; i++) if (v[i]) exp_idx.push_back(i);
`endif
        if (exp_idx.size() == 0) begin
            exp_idx.push_back(0); exp_cnt.push_back(0);
            exp_last.push_back(1); exp_none.push_back(1);
        end else begin
            for (int i = 0; i < exp_idx.size(); i++) begin
                exp_cnt.push_back(i + 1);
                exp_last.push_back(i == exp_idx.size() - 1 ? 1 : 0);
                exp_none.push_back(0);
            end
        end
    endtask

    // Present a vector and complete the input handshake; returns just after the accept edge.
    task automatic send_vec(input logic [15:0] v);
        bit ok = 0;
        in_vec   = v;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_vec   = 16'($urandom);
    endtask

    // Drain beats: ready held low for 'hold' cycles, then high (or random if rnd).
    task automatic collect(input int hold, input bit rnd);
        bit          done  = 0;
        bit          stall = 0;
        logic [10:0] prev  = '0;
        int          c     = 0;
        got_idx.delete(); got_cnt.delete(); got_last.delete(); got_none.delete(); got_cyc.delete();
        seen_first = 0;
        out_ready  = (hold == 0);
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (out_valid) begin
                if (out_count == 5'd1) seen_first++;
                if (stall) begin
                    n_checks++;
                    if ({out_idx, out_count, out_last, out_none} !== prev) begin
                        n_fail++;
                        $display("FAIL stall_stable got=%h required=%h", {out_idx, out_count, out_last, out_none}, prev);
                    end
                end
                if (out_ready) begin
                    got_idx.push_back(int'(out_idx));  got_cnt.push_back(int'(out_count));
                    got_last.push_back(int'(out_last)); got_none.push_back(int'(out_none));
                    got_cyc.push_back(cyc);
                    done = out_last;
                end
                stall = !out_ready;
                prev  = {out_idx, out_count, out_last, out_none};
            end
            @(posedge clk); #1;
            c++;
            out_ready = (c >= hold) && (!rnd || $urandom_range(3) != 0);
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL collect_timeout beats=%0d required_last=1", got_idx.size());
        end
        out_ready = 1'b1;
        @(negedge clk);
        tail_ready = in_ready && !out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_vec = 16'hFFFF; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_idx, out_count, out_last, out_none} !== 13'b1_0_0000_00000_0_0) begin
            n_fail++;
            $display("FAIL reset_state got=%b required=%b",
                     {in_ready, out_valid, out_idx, out_count, out_last, out_none}, 13'b1_0_0000_00000_0_0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_last} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release got=%b required=100", {in_ready, out_valid, out_last});
        end
    endtask

    task automatic test_empty();
        send_vec(16'h0000); model(16'h0000); collect(0, 0);
        n_checks++;
        if (got_idx.size() != 1 || got_idx[0] != 0 || got_cnt[0] != 0 || got_last[0] != 1 || got_none[0] != 1) begin
            n_fail++;
            $display("FAIL empty_beat beats=%0d idx=%0d cnt=%0d last=%0d none=%0d required 1 beat idx0 cnt0 last1 none1",
                     got_idx.size(), got_idx.size() ? got_idx[0] : -1, got_cnt.size() ? got_cnt[0] : -1,
                     got_last.size() ? got_last[0] : -1, got_none.size() ? got_none[0] : -1);
        end
        n_checks++;
        if (got_cyc.size() != 1 || got_cyc[0] != acc_cyc) begin
            n_fail++;
            $display("FAIL empty_latency got_cyc=%0d required=%0d", got_cyc.size() ? got_cyc[0] : -1, acc_cyc);
        end
        n_checks++;
        if (!tail_ready) begin
            n_fail++;
            $display("FAIL empty_turnaround in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_pattern();
        send_vec(16'h8421); model(16'h8421); collect(0, 0);
        n_checks++;
        if (got_idx.size() != exp_idx.size()) begin
            n_fail++;
            $display("FAIL pattern_len got=%0d required=%0d", got_idx.size(), exp_idx.size());
        end else begin
            for (int i = 0; i < exp_idx.size(); i++) begin
                n_checks++;
                if (got_idx[i] != exp_idx[i] || got_cnt[i] != exp_cnt[i] || got_last[i] != exp_last[i]
                    || got_none[i] != exp_none[i] || got_cyc[i] != acc_cyc + i) begin
                    n_fail++;
                    $display("FAIL pattern_beat%0d got idx=%0d cnt=%0d last=%0d cyc=%0d required idx=%0d cnt=%0d last=%0d cyc=%0d",
                             i, got_idx[i], got_cnt[i], got_last[i], got_cyc[i],
                             exp_idx[i], exp_cnt[i], exp_last[i], acc_cyc + i);
                end
            end
        end
        n_checks++;
        if (!tail_ready) begin
            n_fail++;
            $display("FAIL pattern_turnaround in_ready=%0b required=1", in_ready);
        end
    endtask

    task automatic test_full();
        send_vec(16'hFFFF); model(16'hFFFF); collect(0, 0);
        n_checks++;
        if (got_idx.size() != 16) begin
            n_fail++;
            $display("FAIL full_len got=%0d required=16", got_idx.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (got_idx[i] != exp_idx[i] || got_cnt[i] != exp_cnt[i] || got_last[i] != exp_last[i]) begin
                    n_fail++;
                    $display("FAIL full_beat%0d got idx=%0d cnt=%0d last=%0d required idx=%0d cnt=%0d last=%0d",
                             i, got_idx[i], got_cnt[i], got_last[i], exp_idx[i], exp_cnt[i], exp_last[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        send_vec(16'h0030); model(16'h0030); collect(3, 0);
        n_checks++;
        if (seen_first != 4) begin
            n_fail++;
            $display("FAIL bp_hold_cycles got=%0d required=4", seen_first);
        end
        n_checks++;
        if (got_idx.size() != 2 || got_idx[0] != exp_idx[0] || got_idx[1] != exp_idx[1]
            || got_cnt[1] != 2 || got_last[0] != 0 || got_last[1] != 1) begin
            n_fail++;
            $display("FAIL bp_beats got_len=%0d required idx %0d,%0d cnt 1,2 last on second",
                     got_idx.size(), exp_idx[0], exp_idx[1]);
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int n = 0; n < 30; n++) begin
            v = 16'($urandom);
            if (n % 3 == 1) v = v & 16'($urandom);
            if (n % 10 == 5) v = 16'h0000;
            send_vec(v); model(v); collect(0, n % 2 == 0);
            n_checks++;
            if (got_idx.size() != exp_idx.size()
                || got_cnt[got_cnt.size() - 1] != $countones(v)) begin
                n_fail++;
                $display("FAIL random_count vec=%h beats=%0d final_cnt=%0d required beats=%0d cnt=%0d",
                         v, got_idx.size(), got_cnt.size() ? got_cnt[got_cnt.size() - 1] : -1,
                         exp_idx.size(), $countones(v));
            end else begin
                for (int i = 0; i < exp_idx.size(); i++) begin
                    n_checks++;
                    if (got_idx[i] != exp_idx[i] || got_cnt[i] != exp_cnt[i]
                        || got_last[i] != exp_last[i] || got_none[i] != exp_none[i]) begin
                        n_fail++;
                        $display("FAIL random_beat vec=%h i=%0d got idx=%0d cnt=%0d last=%0d none=%0d required idx=%0d cnt=%0d last=%0d none=%0d",
                                 v, i, got_idx[i], got_cnt[i], got_last[i], got_none[i],
                                 exp_idx[i], exp_cnt[i], exp_last[i], exp_none[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_vec(16'h00FF);
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, out_count} !== 7'b0_1_00000) begin
            n_fail++;
            $display("FAIL reset_mid got valid=%0b ready=%0b cnt=%0d required 0/1/0", out_valid, in_ready, out_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send_vec(16'h0002); model(16'h0002); collect(0, 0);
        n_checks++;
        if (got_idx.size() != 1 || got_idx[0] != 1 || got_cnt[0] != 1 || got_last[0] != 1 || got_none[0] != 0) begin
            n_fail++;
            $display("FAIL reset_mid_next beats=%0d idx=%0d cnt=%0d required 1 beat idx1 cnt1",
                     got_idx.size(), got_idx.size() ? got_idx[0] : -1, got_cnt.size() ? got_cnt[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_pattern();
        test_full();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ones_index_serializer.md
# ones_index_serializer

Sequential companion to the ones-counter: instead of summarising a vector as a population count, it enumerates the vector's set bits. It accepts one `inCount`-bit vector per transaction over a valid/ready handshake and emits the index of each set bit, one per beat, on a valid/ready output stream. Each beat carries a running ordinal, so the final beat's ordinal equals the vector's popcount. It sits downstream of the bit-vector producers that currently feed the ones-counter, and drives per-bit consumers such as request dispatch and error-bit logging.

## Interface
- `inCount`, 16: input vector width; must be ≥ 2.
- `outCount`, `$clog2(inCount)`: derived; not overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_vec`  in  `inCount`  vector to enumerate.
- `in_valid`  in  1  `in_vec` valid.
- `in_ready`  out  1  block can accept a vector.
- `out_idx`  out  `outCount`  bit position of the current set bit.
- `out_count`  out  `outCount+1`  1-based ordinal of the current beat; 0 on the empty beat.
- `out_last`  out  1  final beat of this vector.
- `out_none`  out  1  vector had no set bits; only asserted with `out_last`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts the beat.

## Operation
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- States:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - EMIT: `in_ready`=0, `out_valid`=1.
- Reset values: state IDLE, internal mask 0, ordinal 0; `in_ready`=1, `out_valid`=0, `out_idx`=0, `out_count`=0, `out_last`=0, `out_none`=0.
- IDLE→EMIT on `in_valid && in_ready`:
  - `in_vec` is captured into a mask register.
  - The ordinal register is set to 1, or to 0 if `in_vec`==0.
- In EMIT:
  - `out_idx` = priority-encoded position of the selected set bit of the mask (LSB-first by default).
  - `out_last` = 1 when the mask has at most one set bit.
- On `out_valid && out_ready` in EMIT:
  - The emitted bit is cleared from the mask and the ordinal increments.
  - If `out_last`, the block returns to IDLE.
- Empty vector: exactly one beat with `out_none`=1, `out_last`=1, `out_idx`=0, `out_count`=0.
- Full vector (all ones): `inCount` beats.
  - `out_count` reaches `inCount`. It needs `outCount+1` bits, and there is no wrap.
- Output stability: while `out_valid && !out_ready`, all `out_*` signals hold steady. Backpressure never drops or duplicates a beat.
- `in_vec` is ignored outside IDLE. Input handshake and output handshake can never coincide.
- Reset mid-transaction: the partial sequence is discarded immediately and the block is back in IDLE.

## Timing
- Load latency: a vector accepted at edge k has its first beat valid in cycle k+1. Outputs come from registers through the priority encoder, with no combinational path from input to output.
- Throughput: one index per cycle when `out_ready`=1. A vector with N ≥ 1 set bits has beats in cycles k+1..k+N.
- Turnaround: after the last handshake at edge k+N, `in_ready`=1 in cycle k+N+1, so there is one idle cycle between vectors.
- Total occupancy per vector: N+1 cycles with no backpressure (2 cycles for the empty vector).

## Configuration
- `ONES_IDX_MSB_FIRST_EN`:
  - Defined: indices are emitted from the most significant set bit down.
  - Undefined: indices are emitted from the least significant set bit up.
- Everything else is unchanged in both builds: `out_count` ordering semantics, `out_last`, `out_none` and timing.

## Structure
- Shared package `ones_pkg`:
  - State enum (IDLE, EMIT).
  - Helper function computing `$clog2`-based widths, also reused by the ones-counter.
- Sub-module `ones_prio_enc`:
  - Parameterised first-set-bit encoder: takes the mask, returns the index plus a "more than one bit set" flag.
  - Direction is selected by `ONES_IDX_MSB_FIRST_EN`.
- Top level holds only the FSM, the mask register and the ordinal counter.

## Test plan
- Reset, then `in_vec`=16'h0000 → one beat: `out_none`=1, `out_last`=1, `out_count`=0; `in_ready`=1 two cycles after accept.
- `in_vec`=16'h8421, `out_ready`=1 → idx 0,5,10,15 with count 1..4 in consecutive cycles, `out_last` on idx 15. With MSB-first: idx 15,10,5,0.
- `in_vec`=16'hFFFF → 16 beats, idx 0..15, final `out_count`=16, and no wrap.
- `in_vec`=16'h0030 with `out_ready` low for 3 cycles on the first beat → idx 4 held stable for 4 cycles, then idx 5 with `out_last`; no drop or duplicate.
- Random vectors → per vector, final `out_count` equals the ones-counter result and the set of emitted indices equals the set bits.
- Deassert `rst_n` mid-way through `in_vec`=16'h00FF → `out_valid`=0 and `in_ready`=1 immediately; the next vector, 16'h0002, yields a single beat idx 1 with count 1.
